apuf_eval_chain: RTL and testbench
==================================

APUF_EVAL_CHAIN -- requirements
Module: apuf_eval_chain

Interface
REQ-001 Parameter N_STAGES, default 64: number of challenge-controlled switch stages in the delay chain.
REQ-002 Parameter REPS, default 7: evaluations per challenge; SHALL be odd and >=1, elaboration error otherwise.
REQ-003 Parameter SETTLE, default 4: cycles per launch-low (discharge) phase and base cycles per launch-high phase; SHALL be >=1.
REQ-004 iclk  input  1  single clock; all state updates on its rising edge.
REQ-005 irst_n  input  1  asynchronous active-low reset.
REQ-006 istart  input  1  request evaluation; accepted only while oready=1.
REQ-007 ichal  input  N_STAGES  challenge; sampled on accept.
REQ-008 iarb  input  1  arbiter decision from external arbiter macro; asynchronous to iclk.
REQ-009 oready  output  1  high in IDLE only.
REQ-010 olaunch  output  1  launch edge driven into both chain inputs.
REQ-011 otop  output  1  top-path chain output, to arbiter.
REQ-012 obot  output  1  bottom-path chain output, to arbiter.
REQ-013 oresp_valid  output  1  one-cycle pulse, result available.
REQ-014 oresp  output  1  majority-voted response bit.
REQ-015 oones  output  CNT_W  count of evaluations sampling 1; CNT_W = clog2(REPS+1).

Function
REQ-016 Chain: stage i takes (top_in, bot_in) and challenge bit c = latched ichal[i]; c=1 straight (top_out=top_in, bot_out=bot_in), c=0 crossed (top_out=bot_in, bot_out=top_in).
REQ-017 Stage 0 inputs both driven by olaunch; otop/obot are stage N_STAGES-1 outputs, purely combinational from latched challenge and olaunch.
REQ-018 iarb SHALL pass through a 2-flop synchroniser before use.
REQ-019 FSM states: IDLE, LOW, HIGH, DONE.
REQ-020 IDLE: oready=1, olaunch=0; istart=1 -> latch ichal, clear ones count and repetition counter, go LOW.
REQ-021 LOW: olaunch=0 for exactly SETTLE cycles, then HIGH.
REQ-022 HIGH: olaunch=1 for exactly SETTLE+2 cycles; on last cycle add synchronised iarb to ones count, increment repetition counter; if counter reaches REPS go DONE, else LOW.
REQ-023 DONE: one cycle; oresp_valid=1, oresp=(ones > REPS/2), oones=ones; then IDLE.
REQ-024 Latency: istart accepted at edge k -> oresp_valid high in cycle k + REPS*(2*SETTLE+2) + 1 (71 for defaults).
REQ-025 oresp and oones SHALL hold their last values until the next DONE.
REQ-026 istart while oready=0 SHALL be ignored, not queued.
REQ-027 ichal changes after accept SHALL not affect chain routing until next accept.
REQ-028 Ones counter SHALL not wrap: maximum value REPS fits CNT_W.
REQ-029 Majority ties SHALL be impossible (REPS odd).

Reset
REQ-030 irst_n low SHALL immediately force state IDLE, olaunch=0, oready=1, oresp_valid=0, oresp=0, oones=0, latched challenge=0, counters=0, synchroniser flops=0.
REQ-031 Reset mid-evaluation SHALL abort it with no oresp_valid pulse; first accept after deassertion starts a full fresh evaluation.

Structure
REQ-032 Shared package apuf_pkg SHALL hold the FSM state enum, default parameter constants and the clog2 helper.
REQ-033 Sub-module apuf_stage SHALL implement one switch stage (two 2:1 multiplexers sharing the challenge select); apuf_eval_chain instantiates N_STAGES of it in a generate loop.
REQ-034 Chain stages SHALL be kept (no optimisation across stages) via the team's keep attributes.

Verification
REQ-035 Reset mid-HIGH: irst_n low -> same cycle olaunch=0, oready=1, oones=0; no oresp_valid afterwards.
REQ-036 iarb=1 constant, ichal=all ones, istart at cycle k -> oresp_valid only at k+71, oresp=1, oones=7.
REQ-037 iarb=1 for reps 1-3, 0 for reps 4-7 -> oresp=0, oones=3; iarb=1 for reps 1-4 -> oresp=1, oones=4.
REQ-038 istart pulsed during HIGH and ichal changed mid-run -> ignored; one oresp_valid only; routing unchanged.
REQ-039 apuf_stage unit: top_in=1, bot_in=0, c=0 -> top_out=0, bot_out=1; c=1 -> top_out=1, bot_out=0.
REQ-040 Chain, any ichal (all 0, all 1, 0xAAAA...): otop=obot=olaunch every cycle.

Source files
------------

// File: rtl/apuf_pkg.sv
// ---------------------------------------------------------------------------
// apuf_pkg
// Shared definitions for the arbiter-PUF evaluation chain:
//   - apuf_state_e : evaluation FSM states
//   - *_DEF        : default values for the top-level parameters
//   - clog2()      : ceiling log2 helper used to size counters (min 1 bit)
// ---------------------------------------------------------------------------
package apuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } apuf_state_e;

  localparam int N_STAGES_DEF = 64;
  localparam int REPS_DEF     = 7;
  localparam int SETTLE_DEF   = 4;

  // Number of bits needed to hold values 0 .. value-1, never less than 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res < 1) begin
      res = 1;
    end
    return res;
  endfunction

endpackage : apuf_pkg

// File: rtl/apuf_stage.sv
// ---------------------------------------------------------------------------
// apuf_stage
// One switch stage of the arbiter-PUF delay chain: two 2:1 multiplexers that
// share the challenge select.
//   top_i, bot_i : incoming top / bottom path
//   chal_i       : 1 = straight, 0 = crossed
//   top_o, bot_o : outgoing top / bottom path
// ---------------------------------------------------------------------------
module apuf_stage (
  input  logic top_i,
  input  logic bot_i,
  input  logic chal_i,
  output logic top_o,
  output logic bot_o
);

  assign top_o = chal_i ? top_i : bot_i;
  assign bot_o = chal_i ? bot_i : top_i;

endmodule : apuf_stage

// File: rtl/apuf_eval_chain.sv
// ---------------------------------------------------------------------------
// apuf_eval_chain
// Arbiter-PUF evaluation controller with the challenge-routed delay chain.
// Each accepted request latches the challenge and runs REPS launch cycles
// (SETTLE cycles low, SETTLE+2 cycles high); the synchronised arbiter bit is
// sampled on the last high cycle of each repetition and the result is
// majority-voted.
//   iclk        : clock
//   irst_n      : asynchronous active-low reset
//   istart      : evaluation request, taken only while oready=1
//   ichal       : challenge, latched on accept
//   iarb        : arbiter decision (asynchronous, synchronised internally)
//   oready      : idle, request can be accepted
//   olaunch     : launch edge into both chain inputs
//   otop, obot  : chain outputs to the external arbiter
//   oresp_valid : one-cycle result strobe
//   oresp       : majority-voted response (held until next result)
//   oones       : number of repetitions that sampled 1 (held)
// ---------------------------------------------------------------------------
module apuf_eval_chain
  import apuf_pkg::*;
#(
  parameter  int N_STAGES = N_STAGES_DEF,
  parameter  int REPS     = REPS_DEF,
  parameter  int SETTLE   = SETTLE_DEF,
  localparam int CNT_W    = clog2(REPS + 1)
) (
  input  logic                iclk,
  input  logic                irst_n,
  input  logic                istart,
  input  logic [N_STAGES-1:0] ichal,
  input  logic                iarb,
  output logic                oready,
  output logic                olaunch,
  output logic                otop,
  output logic                obot,
  output logic                oresp_valid,
  output logic                oresp,
  output logic [CNT_W-1:0]    oones
);

  // Phase counter must reach SETTLE+1 (last high cycle).
  localparam int PH_W = clog2(SETTLE + 2);

  if ((REPS < 1) || ((REPS % 2) == 0)) begin : g_bad_reps
    $error("apuf_eval_chain: REPS must be odd and >= 1");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("apuf_eval_chain: SETTLE must be >= 1");
  end
  if (N_STAGES < 1) begin : g_bad_stages
    $error("apuf_eval_chain: N_STAGES must be >= 1");
  end

  apuf_state_e         state_q, state_d;
  logic [N_STAGES-1:0] chal_q, chal_d;
  logic [CNT_W-1:0]    ones_q, ones_d;
  logic [CNT_W-1:0]    rep_q, rep_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic                resp_q, resp_d;
  logic [CNT_W-1:0]    oones_q, oones_d;
  logic                arb_meta_q, arb_sync_q;

  // ---------------- arbiter synchroniser ----------------
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      arb_meta_q <= 1'b0;
      arb_sync_q <= 1'b0;
    end else begin
      arb_meta_q <= iarb;
      arb_sync_q <= arb_meta_q;
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= ST_IDLE;
      chal_q  <= '0;
      ones_q  <= '0;
      rep_q   <= '0;
      phase_q <= '0;
      resp_q  <= 1'b0;
      oones_q <= '0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      ones_q  <= ones_d;
      rep_q   <= rep_d;
      phase_q <= phase_d;
      resp_q  <= resp_d;
      oones_q <= oones_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    ones_d  = ones_q;
    rep_d   = rep_q;
    phase_d = phase_q;
    resp_d  = resp_q;
    oones_d = oones_q;
    unique case (state_q)
      ST_IDLE: begin
        if (istart) begin
          chal_d  = ichal;
          ones_d  = '0;
          rep_d   = '0;
          phase_d = '0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_q == PH_W'(SETTLE - 1)) begin
          phase_d = '0;
          state_d = ST_HIGH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_q == PH_W'(SETTLE + 1)) begin
          phase_d = '0;
          ones_d  = ones_q + CNT_W'(arb_sync_q);
          rep_d   = rep_q + 1'b1;
          if (rep_q == CNT_W'(REPS - 1)) begin
            // Result registers load on the way into DONE so they are
            // already valid during the strobe cycle.
            resp_d  = (ones_d > CNT_W'(REPS / 2));
            oones_d = ones_d;
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decoded from the state register so reset forces them immediately.
  assign oready      = (state_q == ST_IDLE);
  assign olaunch     = (state_q == ST_HIGH);
  assign oresp_valid = (state_q == ST_DONE);
  assign oresp       = resp_q;
  assign oones       = oones_q;

  // ---------------- delay chain ----------------
  // Each stage lives in its own generate scope so no vector is both read and
  // written along the chain.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_chain
    logic top_in;
    logic bot_in;
    (* keep = "true" *) logic top_out;
    (* keep = "true" *) logic bot_out;

    if (gi == 0) begin : g_head
      assign top_in = olaunch;
      assign bot_in = olaunch;
    end else begin : g_link
      assign top_in = g_chain[gi-1].top_out;
      assign bot_in = g_chain[gi-1].bot_out;
    end

    (* keep_hierarchy = "yes", dont_touch = "true" *)
    apuf_stage u_stage (
      .top_i  (top_in),
      .bot_i  (bot_in),
      .chal_i (chal_q[gi]),
      .top_o  (top_out),
      .bot_o  (bot_out)
    );
  end

  assign otop = g_chain[N_STAGES-1].top_out;
  assign obot = g_chain[N_STAGES-1].bot_out;

endmodule : apuf_eval_chain

// File: tb/tb_apuf_eval_chain.sv
module tb_apuf_eval_chain;

  localparam int N      = 64;
  localparam int REPS   = 7;
  localparam int SETTLE = 4;
  localparam int CNT_W  = 3;
  localparam int P      = 2 * SETTLE + 2;

  logic             clk;
  logic             rst_n;
  logic             istart;
  logic [N-1:0]     ichal;
  logic             iarb;
  logic             oready, olaunch, otop, obot, oresp_valid, oresp;
  logic [CNT_W-1:0] oones;

  logic st_top, st_bot, st_c, st_to, st_bo;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // behavioural model state
  bit           busy      = 0;
  int           busy_from = 0;
  logic [N-1:0] m_chal    = '0;
  int           last_ones = 0;
  bit           last_resp = 0;
  bit           arb_pat [REPS];

  apuf_eval_chain #(.N_STAGES(N), .REPS(REPS), .SETTLE(SETTLE)) dut (
    .iclk        (clk),
    .irst_n      (rst_n),
    .istart      (istart),
    .ichal       (ichal),
    .iarb        (iarb),
    .oready      (oready),
    .olaunch     (olaunch),
    .otop        (otop),
    .obot        (obot),
    .oresp_valid (oresp_valid),
    .oresp       (oresp),
    .oones       (oones)
  );

  apuf_stage u_stage_ut (
    .top_i  (st_top),
    .bot_i  (st_bot),
    .chal_i (st_c),
    .top_o  (st_to),
    .bot_o  (st_bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle-accurate model: evaluation begins the cycle after the accepting
  // cycle; each repetition is SETTLE low + SETTLE+2 high; DONE follows.
  always @(negedge clk) begin : cmp
    int   t, t2, eo;
    bit   el, ev;
    logic tp, bt, sw;
    if (!rst_n) begin
      busy      = 0;
      last_ones = 0;
      last_resp = 0;
      m_chal    = '0;
    end else begin
      t  = cyc - busy_from;
      el = busy && (t < REPS * P) && ((t % P) >= SETTLE);
      ev = busy && (t == REPS * P);
      if (ev) begin
        eo = 0;
        for (int r = 0; r < REPS; r++) eo += int'(arb_pat[r]);
        last_ones = eo;
        last_resp = (2 * eo > REPS);
      end
      tp = el;
      bt = el;
      for (int i = 0; i < N; i++) begin
        if (!m_chal[i]) begin
          sw = tp; tp = bt; bt = sw;
        end
      end
      chk("ready", 32'(oready), 32'(!busy));
      chk("launch", 32'(olaunch), 32'(el));
      chk("otop", 32'(otop), 32'(tp));
      chk("obot", 32'(obot), 32'(bt));
      chk("resp_valid", 32'(oresp_valid), 32'(ev));
      chk("resp_hold", 32'(oresp), 32'(last_resp));
      chk("ones_hold", 32'(oones), 32'(last_ones));
      if (ev) begin
        busy = 0;
      end else if (!busy && istart) begin
        busy      = 1;
        busy_from = cyc + 1;
        m_chal    = ichal;
      end
      t2 = cyc - busy_from;
      if (busy && t2 >= 0 && (t2 % P) == 0 && (t2 / P) < REPS) begin
        iarb = arb_pat[t2 / P];
      end
    end
  end

  task automatic wait_valid(output int vcyc);
    vcyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (oresp_valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
    end
    if (vcyc < 0) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_eval(input logic [N-1:0] chal, input logic [REPS-1:0] pat, output int k);
    @(posedge clk); #1;
    for (int r = 0; r < REPS; r++) arb_pat[r] = pat[r];
    ichal  = chal;
    istart = 1'b1;
    k      = cyc;
    @(posedge clk); #1;
    istart = 1'b0;
  endtask

  task automatic run_eval(input logic [N-1:0] chal, input logic [REPS-1:0] pat,
                          input int exp_ones, input bit exp_resp);
    int k, v;
    start_eval(chal, pat, k);
    wait_valid(v);
    chk("latency", 32'(v - k), 32'd71);
    chk("ones_lit", 32'(oones), 32'(exp_ones));
    chk("resp_lit", 32'(oresp), 32'(exp_resp));
    $display("EVAL chal=%h pat=%b ones=%0d resp=%0d latency=%0d", chal, pat, oones, oresp, v - k);
    @(negedge clk);
    chk("ready_after", 32'(oready), 32'd1);
  endtask

  initial begin
    int k, v;
    bit seen;
    rst_n  = 1'b0;
    istart = 1'b0;
    ichal  = '0;
    iarb   = 1'b0;
    st_top = 1'b1; st_bot = 1'b0; st_c = 1'b0;
    #1;
    chk("stage_c0_top", 32'(st_to), 32'd0);
    chk("stage_c0_bot", 32'(st_bo), 32'd1);
    st_c = 1'b1; #1;
    chk("stage_c1_top", 32'(st_to), 32'd1);
    chk("stage_c1_bot", 32'(st_bo), 32'd0);
    st_top = 1'b0; st_bot = 1'b1; st_c = 1'b0; #1;
    chk("stage_c0_swap_top", 32'(st_to), 32'd1);
    chk("stage_c0_swap_bot", 32'(st_bo), 32'd0);

    chk("rst_ready", 32'(oready), 32'd1);
    chk("rst_launch", 32'(olaunch), 32'd0);
    chk("rst_valid", 32'(oresp_valid), 32'd0);
    chk("rst_resp", 32'(oresp), 32'd0);
    chk("rst_ones", 32'(oones), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_eval({N{1'b1}}, 7'b1111111, 7, 1'b1);
    run_eval(64'hAAAA_AAAA_AAAA_AAAA, 7'b0000111, 3, 1'b0);
    run_eval('0, 7'b0001111, 4, 1'b1);
    run_eval(64'h0123_4567_89AB_CDEF, 7'b0000000, 0, 1'b0);

    // start pulsed while busy and challenge changed mid-run
    start_eval(64'h5555_0000_FFFF_1234, 7'b0101010, k);
    repeat (15) @(posedge clk);
    #1;
    istart = 1'b1;
    ichal  = {$urandom, $urandom};
    @(posedge clk); #1;
    istart = 1'b0;
    ichal  = ~ichal;
    wait_valid(v);
    chk("busy_latency", 32'(v - k), 32'd71);
    chk("busy_ones", 32'(oones), 32'd3);
    chk("busy_resp", 32'(oresp), 32'd0);
    $display("EVAL busy-start ones=%0d resp=%0d latency=%0d", oones, oresp, v - k);
    repeat (100) @(posedge clk);

    // reset asserted during a high phase
    start_eval({N{1'b1}}, 7'b1111111, k);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (olaunch === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("reach_high", 32'(seen), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_launch", 32'(olaunch), 32'd0);
    chk("midrst_ready", 32'(oready), 32'd1);
    chk("midrst_ones", 32'(oones), 32'd0);
    chk("midrst_resp", 32'(oresp), 32'd0);
    chk("midrst_valid", 32'(oresp_valid), 32'd0);
    $display("EVAL reset-abort launch=%0d ready=%0d ones=%0d", olaunch, oready, oones);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (90) @(posedge clk);
    run_eval({N{1'b1}}, 7'b1111111, 7, 1'b1);
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_apuf_eval_chain
